// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe
// EX/MEM and MEM/WB pipeline registers plus the data-memory handshake.
// A multi-cycle memory access holds the pipeline (stall_o) and bubbles
// MEM/WB until the memory reports ready. stall_count tallies stalled cycles.
//
// Ports
//   clk, rst                 core clock, synchronous active-high reset
//   ex_*                     instruction fields arriving from EX
//   dmem_req/we/addr/wdata   request to data memory
//   dmem_ready, dmem_rdata   memory completion and load data
//   stall_o                  hold PC, IF/ID, ID/EX and EX inputs
//   EX_MEM_*                 EX/MEM destination, write enable, ALU result
//   MEM_WB_*                 MEM/WB destination, write enable, write data
//   stall_count              free-running count of stalled cycles
//
// Memory FSM
//   state   | meaning
//   ST_RUN  | no request outstanding
//   ST_WAIT | request issued, dmem_ready not yet seen
module ex_mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_memtoreg,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_o,
  output logic [REG_W-1:0]  EX_MEM_Rd,
  output logic              EX_MEM_RegWrite,
  output logic [DATA_W-1:0] EX_MEM_ALUResult,
  output logic [REG_W-1:0]  MEM_WB_Rd,
  output logic              MEM_WB_RegWrite,
  output logic [DATA_W-1:0] MEM_WB_WriteData,
  output logic [31:0]       stall_count
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t              r_state;

  logic                r_em_valid;
  logic [REG_W-1:0]    r_em_rd;
  logic                r_em_regwrite;
  logic                r_em_memread;
  logic                r_em_memwrite;
  logic                r_em_memtoreg;
  logic [DATA_W-1:0]   r_em_alu;
  logic [DATA_W-1:0]   r_em_sdata;

  logic                r_wb_valid;
  logic [REG_W-1:0]    r_wb_rd;
  logic                r_wb_regwrite;
  logic [DATA_W-1:0]   r_wb_data;

  logic [31:0]         r_stall_count;

  logic                w_mem_op;
  logic                w_stall;

  assign w_mem_op = r_em_valid & (r_em_memread | r_em_memwrite);
  // Reset gates the request so an abandoned access is dropped in the reset cycle itself.
  assign w_stall  = w_mem_op & ~dmem_ready & ~rst;

  assign dmem_req   = w_mem_op & ~rst;
  assign dmem_we    = r_em_memwrite;
  assign dmem_addr  = r_em_alu;
  assign dmem_wdata = r_em_sdata;
  assign stall_o    = w_stall;

  assign EX_MEM_Rd        = r_em_rd;
  assign EX_MEM_RegWrite  = r_em_valid & r_em_regwrite;
  assign EX_MEM_ALUResult = r_em_alu;
  assign MEM_WB_Rd        = r_wb_rd;
  assign MEM_WB_RegWrite  = r_wb_valid & r_wb_regwrite;
  assign MEM_WB_WriteData = r_wb_data;
  assign stall_count      = r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_em_valid    <= 1'b0;
      r_em_rd       <= '0;
      r_em_regwrite <= 1'b0;
      r_em_memread  <= 1'b0;
      r_em_memwrite <= 1'b0;
      r_em_memtoreg <= 1'b0;
      r_em_alu      <= '0;
      r_em_sdata    <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_regwrite <= 1'b0;
      r_wb_data     <= '0;
      r_stall_count <= '0;
    end else begin
      case (r_state)
        ST_RUN:  if (w_mem_op && !dmem_ready) r_state <= ST_WAIT;
        ST_WAIT: if (dmem_ready)              r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase

      if (w_stall) begin
        // EX/MEM holds the outstanding access; MEM/WB sees a bubble.
        r_wb_valid    <= 1'b0;
        r_stall_count <= r_stall_count + 32'd1;
      end else begin
        r_em_valid    <= ex_valid;
        r_em_rd       <= ex_rd;
        r_em_regwrite <= ex_regwrite;
        r_em_memread  <= ex_memread;
        r_em_memwrite <= ex_memwrite;
        r_em_memtoreg <= ex_memtoreg;
        r_em_alu      <= ex_alu_result;
        r_em_sdata    <= ex_store_data;

        r_wb_valid    <= r_em_valid;
        r_wb_rd       <= r_em_rd;
        r_wb_regwrite <= r_em_regwrite;
        r_wb_data     <= r_em_memtoreg ? dmem_rdata : r_em_alu;
      end
    end
  end

endmodule
